ws2812_framebuf: RTL
====================

// Module: ws2812_framebuf
// PURPOSE
//  Double-buffered 24-bit GRB colour store feeding the WS2812 serialiser's fetch port.
//  A host-side writer fills the back bank while the serialiser reads the front bank by LED address.
//  On commit, the banks swap at the next frame boundary (last LED fetched), so a frame never tears.
// PARAMETERS
//  N_LEDS    64  LEDs per frame; addresses 0..N_LEDS-1
//  ADDR_W    6   address width, >= $clog2(N_LEDS)
// PORTS
//  clk           in   1       system clock
//  rst_n         in   1       reset, asynchronous, active-low
//  wr_valid      in   1       write request
//  wr_ready      out  1       write accepted when wr_valid && wr_ready
//  wr_addr       in   ADDR_W  LED index to write (back bank)
//  wr_color      in   24      GRB colour, G in [23:16]
//  wr_commit     in   1       1-cycle pulse: back bank complete, request swap
//  commit_pend   out  1       swap requested, not yet performed
//  rd_start      in   1       fetch strobe from serialiser; a fetch is its rising edge
//  rd_addr       in   ADDR_W  LED index to fetch (front bank)
//  rd_color      out  24      fetched colour, held until next fetch
//  rd_valid      out  1       rd_color valid for the latest fetch
//  dim_shift     in   3       brightness shift (only with WS_FB_DIM_EN)
// BEHAVIOUR
//  Reset: front bank=0, commit_pend=0, wr_ready=1, rd_color=0, rd_valid=0, rd_start edge reg=0.
//    RAM contents are not reset.
//  Fetch: edge = rd_start & ~rd_start_q. Edge at cycle T: rd_addr is sampled at T.
//    rd_valid drops at T+1; rd_color/rd_valid=1 appear at T+2 (fixed latency 2).
//    rd_start held high for many cycles = one fetch. A new edge while a fetch is in flight
//    restarts the fetch with the new address.
//  rd_addr >= N_LEDS: rd_color=0, rd_valid=1 at the same latency.
//  Write: on wr_valid&&wr_ready, wr_color -> back bank[wr_addr]. wr_addr >= N_LEDS: accepted, discarded.
//  wr_ready = ~commit_pend: the back bank is frozen between commit and swap.
//  Commit: wr_commit sets commit_pend. A write accepted in the same cycle is part of the frame.
//    wr_commit while commit_pend=1 is ignored.
//  Swap: when a fetch of address N_LEDS-1 completes (cycle T+2) with commit_pend=1,
//    front bank toggles and commit_pend clears in that cycle. wr_ready=1 from T+3.
//    The completed fetch returns old-front-bank data.
//  After a swap, the new back bank holds the previous front frame; the writer overwrites it.
//  Fetch and write are fully concurrent: separate ports, different banks, no stalls.
//  Reset mid-frame: pending commit is lost and the front bank returns to 0.
//    The serialiser restarts its own frame.
// CONFIGURATION
//  WS_FB_DIM_EN defined: dim_shift port present. Each 8-bit channel of rd_color is
//    (ch >> dim_shift), applied before the output register, so latency is unchanged.
//    dim_shift is sampled at the fetch edge.
//  WS_FB_DIM_EN undefined: no dim_shift port; rd_color is the raw stored value.
// STRUCTURE
//  ws_fb_pkg: COLOR_W=24, CH_W=8, channel slice constants G/R/B, default N_LEDS.
//  Sub-module ws_fb_ram: simple dual-port RAM, (2*N_LEDS) x 24.
//    Address = {bank, led}. 1 write port; 1 registered read port (1-cycle).
//    Infers block RAM. Top level holds the edge detect, bank/commit control, dim and output register.
// TESTING
//  1 Reset, write addr 5=0x0F0101, commit, fetch 0..63 -> swap after addr 63; next frame addr 5 gives 0x0F0101.
//  2 Fetch edge at T with rd_addr=7 -> rd_valid=0 at T+1, rd_valid=1 with data at T+2;
//    rd_start held 30 cycles -> exactly 1 fetch.
//  3 Commit mid-frame (after addr 20) -> wr_ready=0, addrs 21..63 still return old frame,
//    swap at addr 63 completion, wr_ready=1 next cycle.
//  4 Write addr 70 and fetch addr 70 (N_LEDS=64) -> write discarded; rd_color=0, rd_valid=1.
//  5 Write to addr 63 in the same cycle as wr_commit -> new value visible after swap;
//    second wr_commit while pending is ignored (only one swap).
//  6 WS_FB_DIM_EN, stored 0x80FF10, dim_shift=3 -> rd_color=0x101F02;
//    assert rst_n mid-frame -> all outputs at reset values immediately.

Source files
------------

// File: rtl/ws_fb_pkg.sv
// Shared constants for the WS2812 double-buffered frame store.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ws_fb_pkg;

    localparam int COLOR_W    = 24;
    localparam int CH_W       = 8;

    // GRB channel slices within a packed colour word
    localparam int G_HI       = 23;
    localparam int G_LO       = 16;
    localparam int R_HI       = 15;
    localparam int R_LO       = 8;
    localparam int B_HI       = 7;
    localparam int B_LO       = 0;

    localparam int N_LEDS_DEF = 64;
    localparam int ADDR_W_DEF = 6;

    // Shift every 8-bit channel right by the same amount (brightness scaling).
    function automatic logic [COLOR_W-1:0] dim_color(input logic [COLOR_W-1:0] c,
                                                     input logic [2:0]         sh);
        logic [CH_W-1:0] g, r, b;
        g = c[G_HI:G_LO] >> sh;
        r = c[R_HI:R_LO] >> sh;
        b = c[B_HI:B_LO] >> sh;
        return {g, r, b};
    endfunction

endpackage

// File: rtl/ws_fb_ram.sv
// Simple dual-port colour RAM: one write port, one registered read port.
// Latency: read data valid one cycle after re.
// Backpressure: none; both ports accept every cycle.
//
// Ports: clk; we/waddr/wdata write port; re/raddr/rdata registered read port.
// Contents are not reset so the array maps onto block RAM.
module ws_fb_ram #(
    parameter int AW    = 7,
    parameter int DEPTH = 128,
    parameter int W     = 24
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/ws2812_framebuf.sv
// Double-buffered GRB frame store: host writes back bank, serialiser fetches front bank.
// Latency: fetch edge at T -> rd_valid low at T+1, rd_color/rd_valid high at T+2.
// Backpressure: wr_ready low from commit until the bank swap at the end of the frame.
//
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   wr_valid/wr_ready/wr_addr/wr_color  back-bank write handshake
//   wr_commit, commit_pend         swap request pulse / swap pending flag
//   rd_start/rd_addr               fetch strobe (rising edge) and LED index
//   rd_color/rd_valid              fetched colour, held until next fetch
//   dim_shift                      per-channel right shift, only with WS_FB_DIM_EN defined
// Optional feature macro: WS_FB_DIM_EN (brightness dimming on the fetch path).
module ws2812_framebuf
    import ws_fb_pkg::*;
#(
    parameter int N_LEDS = N_LEDS_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [COLOR_W-1:0] wr_color,
    input  logic               wr_commit,
    output logic               commit_pend,
    input  logic               rd_start,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic [COLOR_W-1:0] rd_color,
    output logic               rd_valid
`ifdef WS_FB_DIM_EN
    ,
    input  logic [2:0]         dim_shift
`endif
);

    localparam int                RAM_AW    = ADDR_W + 1;
    localparam int                RAM_DEPTH = 2 << ADDR_W;
    localparam logic [ADDR_W:0]   N_LEDS_W  = (ADDR_W+1)'(N_LEDS);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_LEDS - 1);

    logic               rd_start_q;
    logic               front_bank;
    logic               fetch_edge;
    logic               s1_vld;     // fetch sampled last cycle, RAM data now available
    logic               s1_oob;
    logic               s1_last;
    logic               done_last;  // high in the cycle a fetch of the last LED is presented
    logic               swap_now;
    logic               rd_bank;
    logic               wr_fire;
    logic               ram_we;
    logic [COLOR_W-1:0] ram_rdata;
    logic [COLOR_W-1:0] color_out;
`ifdef WS_FB_DIM_EN
    logic [2:0]         s1_dim;
`endif

    assign fetch_edge = rd_start & ~rd_start_q;
    assign swap_now   = done_last & commit_pend;
    // A fetch issued in the swap cycle already belongs to the new frame.
    assign rd_bank    = front_bank ^ swap_now;
    assign wr_ready   = ~commit_pend;
    assign wr_fire    = wr_valid & wr_ready;
    assign ram_we     = wr_fire & ({1'b0, wr_addr} < N_LEDS_W);

    ws_fb_ram #(
        .AW    (RAM_AW),
        .DEPTH (RAM_DEPTH),
        .W     (COLOR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr ({~front_bank, wr_addr}),
        .wdata (wr_color),
        .re    (fetch_edge),
        .raddr ({rd_bank, rd_addr}),
        .rdata (ram_rdata)
    );

`ifdef WS_FB_DIM_EN
    assign color_out = s1_oob ? '0 : dim_color(ram_rdata, s1_dim);
`else
    assign color_out = s1_oob ? '0 : ram_rdata;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_start_q  <= 1'b0;
            front_bank  <= 1'b0;
            commit_pend <= 1'b0;
            rd_color    <= '0;
            rd_valid    <= 1'b0;
            s1_vld      <= 1'b0;
            s1_oob      <= 1'b0;
            s1_last     <= 1'b0;
            done_last   <= 1'b0;
`ifdef WS_FB_DIM_EN
            s1_dim      <= '0;
`endif
        end else begin
            rd_start_q <= rd_start;
            done_last  <= 1'b0;

            // A new edge always wins over an older fetch still in the pipe.
            if (fetch_edge) begin
                s1_vld   <= 1'b1;
                s1_oob   <= ~({1'b0, rd_addr} < N_LEDS_W);
                s1_last  <= (rd_addr == LAST_ADDR);
                rd_valid <= 1'b0;
`ifdef WS_FB_DIM_EN
                s1_dim   <= dim_shift;
`endif
            end else if (s1_vld) begin
                s1_vld    <= 1'b0;
                rd_color  <= color_out;
                rd_valid  <= 1'b1;
                done_last <= s1_last;
            end

            if (swap_now) begin
                front_bank  <= ~front_bank;
                commit_pend <= 1'b0;
            end else if (wr_commit && !commit_pend) begin
                commit_pend <= 1'b1;
            end
        end
    end

endmodule
